// File: rtl/twiddle_scheduler.sv
// Twiddle scheduler for one radix-2 DIF FFT frame: counts stage/sample, issues twiddle ROM
// reads and multiplies lower-leg samples by W^k. Define TWIDDLE_CONJ_EN for the inverse port.
module twiddle_scheduler #(
   parameter int WIDTH = 16,
   parameter int LOG2N = 6,
   localparam int SW   = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
`ifdef TWIDDLE_CONJ_EN
   input  logic                    inverse,
`endif
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_real,
   input  logic signed [WIDTH-1:0] in_imag,
   output logic [LOG2N-2:0]        tw_addr,
   output logic                    tw_en,
   input  logic signed [WIDTH-1:0] tw_real,
   input  logic signed [WIDTH-1:0] tw_imag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_real,
   output logic signed [WIDTH-1:0] out_imag,
   output logic [SW-1:0]           stage,
   output logic                    busy,
   output logic                    done
);

   localparam int N = 1 << LOG2N;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  r_state;
   logic [LOG2N-1:0]        r_n;
   logic                    r_inv;
   logic                    r_s1Valid;
   logic                    r_s1Bypass;
   logic signed [WIDTH-1:0] r_s1Real;
   logic signed [WIDTH-1:0] r_s1Imag;

   logic                      w_advance;
   logic                      w_accept;
   logic                      w_drained;
   logic [LOG2N-1:0]          w_half;
   logic                      w_lower;
   logic [LOG2N-2:0]          w_k;
   logic signed [WIDTH-1:0]   w_twImag;
   logic signed [2*WIDTH-1:0] w_pRR;
   logic signed [2*WIDTH-1:0] w_pII;
   logic signed [2*WIDTH-1:0] w_pRI;
   logic signed [2*WIDTH-1:0] w_pIR;
   logic signed [WIDTH-1:0]   w_mulRe;
   logic signed [WIDTH-1:0]   w_mulIm;

   // The whole pipeline moves together whenever the output register can hand off.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = (r_state == RUN) && w_advance;
   assign w_accept  = in_valid && in_ready;
   assign w_drained = !r_s1Valid && w_advance;

   assign w_half  = LOG2N'(N >> (int'(stage) + 1));
   assign w_lower = |(r_n & w_half);
   assign w_k     = (LOG2N-1)'((r_n & (w_half - 1'b1)) << stage);
   assign tw_addr = (w_accept && w_lower) ? w_k : '0;
   assign tw_en   = w_accept;

`ifdef TWIDDLE_CONJ_EN
   // Negating the most negative code would overflow, so it clips to the largest positive.
   assign w_twImag = !r_inv ? tw_imag :
                     (tw_imag == {1'b1, {(WIDTH-1){1'b0}}}) ? {1'b0, {(WIDTH-1){1'b1}}} :
                     -tw_imag;
`else
   assign w_twImag = tw_imag;
`endif

   assign w_pRR   = (2*WIDTH)'(r_s1Real) * (2*WIDTH)'(tw_real);
   assign w_pII   = (2*WIDTH)'(r_s1Imag) * (2*WIDTH)'(w_twImag);
   assign w_pRI   = (2*WIDTH)'(r_s1Real) * (2*WIDTH)'(w_twImag);
   assign w_pIR   = (2*WIDTH)'(r_s1Imag) * (2*WIDTH)'(tw_real);
   assign w_mulRe = WIDTH'(w_pRR >>> (WIDTH-1)) - WIDTH'(w_pII >>> (WIDTH-1));
   assign w_mulIm = WIDTH'(w_pRI >>> (WIDTH-1)) + WIDTH'(w_pIR >>> (WIDTH-1));

   // Frame sequencing: stage/sample counters and the busy/done flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_n     <= '0;
         r_inv   <= 1'b0;
         stage   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  busy    <= 1'b1;
                  r_n     <= '0;
                  stage   <= '0;
`ifdef TWIDDLE_CONJ_EN
                  r_inv   <= inverse;
`else
                  r_inv   <= 1'b0;
`endif
               end
            end
            RUN: begin
               if (w_accept) begin
                  if (r_n == LOG2N'(N-1)) begin
                     r_n <= '0;
                     if (stage == SW'(LOG2N-1)) begin
                        stage   <= '0;
                        r_state <= DRAIN;
                     end else begin
                        stage <= stage + 1'b1;
                     end
                  end else begin
                     r_n <= r_n + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_drained) begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // S1 holds the sample while the ROM answers; S2 is the output register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s1Valid  <= 1'b0;
         r_s1Bypass <= 1'b0;
         r_s1Real   <= '0;
         r_s1Imag   <= '0;
         out_valid  <= 1'b0;
         out_real   <= '0;
         out_imag   <= '0;
      end else if (w_advance) begin
         r_s1Valid <= w_accept;
         if (w_accept) begin
            r_s1Real   <= in_real;
            r_s1Imag   <= in_imag;
            r_s1Bypass <= !w_lower;
         end
         out_valid <= r_s1Valid;
         if (r_s1Valid) begin
            out_real <= r_s1Bypass ? r_s1Real : w_mulRe;
            out_imag <= r_s1Bypass ? r_s1Imag : w_mulIm;
         end
      end
   end

endmodule

// File: tb/tb_twiddle_scheduler.sv
// Bench for twiddle_scheduler: streams whole frames, models a synchronous twiddle ROM and
// scores every handshake against a reference model derived from the stage/sample rules.
module tb_twiddle_scheduler;

   localparam int WIDTH = 16;
   localparam int LOG2N = 6;
   localparam int N     = 1 << LOG2N;
   localparam int TOTAL = N * LOG2N;

   logic             clock     = 1'b0;
   logic             reset_n   = 1'b0;
   logic             start     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_real   = '0;
   logic [WIDTH-1:0] in_imag   = '0;
   logic [LOG2N-2:0] tw_addr;
   logic             tw_en;
   logic [WIDTH-1:0] tw_real   = '0;
   logic [WIDTH-1:0] tw_imag   = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_real;
   logic [WIDTH-1:0] out_imag;
   logic [2:0]       stage;
   logic             busy;
   logic             done;
`ifdef TWIDDLE_CONJ_EN
   logic             inverse   = 1'b0;
`endif

   int nPass = 0;
   int nTotal = 0;
   int cycle = 0;
   int accIdx = 0;
   int outIdx = 0;
   int outValidCnt = 0;
   int doneCnt = 0;
   int mPhase = 0;
   bit mDone = 1'b0;
   bit mInv = 1'b0;
   bit noStall = 1'b1;

   logic [15:0] inRe [TOTAL];
   logic [15:0] inIm [TOTAL];
   logic [15:0] expRe [TOTAL];
   logic [15:0] expIm [TOTAL];
   logic [15:0] logRe [TOTAL];
   logic [15:0] logIm [TOTAL];
   int          accCycle [TOTAL];
   logic [15:0] romRe [N/2];
   logic [15:0] romIm [N/2];

   twiddle_scheduler #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
`ifdef TWIDDLE_CONJ_EN
      .inverse  (inverse),
`endif
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_real  (in_real),
      .in_imag  (in_imag),
      .tw_addr  (tw_addr),
      .tw_en    (tw_en),
      .tw_real  (tw_real),
      .tw_imag  (tw_imag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_real (out_real),
      .out_imag (out_imag),
      .stage    (stage),
      .busy     (busy),
      .done     (done)
   );

   always #5 clock = ~clock;

   // Synchronous twiddle ROM: data appears the cycle after an enabled read and holds otherwise.
   always @(posedge clock) begin
      if (tw_en) begin
         tw_real <= romRe[tw_addr];
         tw_imag <= romIm[tw_addr];
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nTotal++;
      if (actual == expected) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   function automatic int expHalf(input int st);
      return N >> (st + 1);
   endfunction

   function automatic bit expLower(input int j);
      int st = j / N;
      int n  = j % N;
      return ((n / expHalf(st)) % 2) == 1;
   endfunction

   function automatic int expAddr(input int j);
      int st = j / N;
      int n  = j % N;
      if (!expLower(j)) return 0;
      return (n % expHalf(st)) * (1 << st);
   endfunction

   function automatic logic [15:0] scale(input int a, input int b);
      real p = real'(a) * real'(b) / 32768.0;
      return 16'(longint'($floor(p)));
   endfunction

   function automatic int negSat(input int b);
      return (b == -32768) ? 32767 : -b;
   endfunction

   function automatic logic [31:0] cmul(input int ar, input int ai, input int br, input int bi);
      logic [15:0] re;
      logic [15:0] im;
      re = scale(ar, br) - scale(ai, bi);
      im = scale(ar, bi) + scale(ai, br);
      return {re, im};
   endfunction

   // Reference model: tracks the frame phase and scores every accept and every output handshake.
   always @(negedge clock) begin
      int ph;
      int j;
      int k;
      int bi;
      cycle++;
      if (!reset_n) begin
         mPhase = 0;
         mDone  = 1'b0;
         accIdx = 0;
         outIdx = 0;
      end else begin
         ph = mPhase;
         checkOutput("busy", busy, ph != 0);
         checkOutput("done", done, mDone);
         checkOutput("tw_en", tw_en, in_valid && in_ready);
         if (ph != 1) checkOutput("in_ready_not_run", in_ready, 0);
         else if (noStall) checkOutput("in_ready_run", in_ready, 1);
         mDone = 1'b0;
         if (done) doneCnt++;
         if (out_valid) outValidCnt++;
         if (in_valid && in_ready) begin
            checkOutput("accept_in_run", (ph == 1) && (accIdx < TOTAL), 1);
            if (ph == 1 && accIdx < TOTAL) begin
               j = accIdx;
               k = expAddr(j);
               checkOutput("tw_addr", tw_addr, k);
               checkOutput("stage", stage, j / N);
               if (expLower(j)) begin
                  bi = int'($signed(romIm[k]));
                  if (mInv) bi = negSat(bi);
                  {expRe[j], expIm[j]} = cmul(int'($signed(inRe[j])), int'($signed(inIm[j])),
                                              int'($signed(romRe[k])), bi);
               end else begin
                  expRe[j] = inRe[j];
                  expIm[j] = inIm[j];
               end
               accCycle[j] = cycle;
               accIdx++;
               if (accIdx == TOTAL) mPhase = 2;
            end
         end
         if (out_valid && out_ready) begin
            checkOutput("out_expected", outIdx < accIdx, 1);
            if (outIdx < accIdx) begin
               checkOutput("out_real", out_real, expRe[outIdx]);
               checkOutput("out_imag", out_imag, expIm[outIdx]);
               if (noStall) checkOutput("latency", cycle - accCycle[outIdx], 2);
               logRe[outIdx] = out_real;
               logIm[outIdx] = out_imag;
               outIdx++;
            end
         end
         if (mPhase == 2 && outIdx == TOTAL) begin
            mPhase = 0;
            mDone  = 1'b1;
         end
         if (ph == 0 && start) begin
            mPhase      = 1;
            accIdx      = 0;
            outIdx      = 0;
            outValidCnt = 0;
            doneCnt     = 0;
`ifdef TWIDDLE_CONJ_EN
            mInv = inverse;
`else
            mInv = 1'b0;
`endif
         end
      end
   end

   task automatic checkReset(input string tag);
      checkOutput({tag, "_in_ready"}, in_ready, 0);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_out_real"}, out_real, 0);
      checkOutput({tag, "_out_imag"}, out_imag, 0);
      checkOutput({tag, "_tw_addr"}, tw_addr, 0);
      checkOutput({tag, "_tw_en"}, tw_en, 0);
      checkOutput({tag, "_stage"}, stage, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
   endtask

   task automatic pinModel();
      checkOutput("model_addr_s0_n32", expAddr(32), 0);
      checkOutput("model_addr_s0_n33", expAddr(33), 1);
      checkOutput("model_addr_s1_n16", expAddr(N + 16), 0);
      checkOutput("model_addr_s1_n17", expAddr(N + 17), 2);
      checkOutput("model_addr_s5_n1", expAddr(5*N + 1), 0);
      checkOutput("model_lower_s0_n31", expLower(31), 0);
      checkOutput("model_lower_s0_n32", expLower(32), 1);
      checkOutput("model_lower_s5_n0", expLower(5*N), 0);
      checkOutput("model_lower_s5_n1", expLower(5*N + 1), 1);
      checkOutput("model_cmul_fwd", cmul(16384, 0, 0, -32768), 32'h0000C000);
      checkOutput("model_cmul_conj", cmul(16384, 0, 0, negSat(16384)), 32'h0000E000);
      checkOutput("model_negsat", negSat(-32768), 32767);
   endtask

   task automatic fillRandom();
      for (int i = 0; i < TOTAL; i++) begin
         inRe[i] = 16'($urandom);
         inIm[i] = 16'($urandom);
      end
      for (int i = 0; i < N/2; i++) begin
         romRe[i] = 16'($urandom);
         romIm[i] = 16'($urandom);
      end
   endtask

   task automatic fillHalf();
      for (int i = 0; i < TOTAL; i++) begin
         inRe[i] = 16'h4000;
         inIm[i] = 16'h0000;
      end
   endtask

   task automatic startFrame();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   // Streams count samples, holding each until accepted; startAt >= 0 pulses a stray start.
   task automatic applyStimulus(input int lowPct, input int count, input int startAt);
      int sent = 0;
      int guard = 0;
      while (sent < count && guard < 5000) begin
         @(posedge clock); #1;
         in_valid  = 1'b1;
         in_real   = inRe[sent];
         in_imag   = inIm[sent];
         out_ready = ($urandom_range(99, 0) >= lowPct);
         start     = (startAt >= 0) && (sent == startAt);
         @(negedge clock);
         if (in_valid && in_ready) sent++;
         guard++;
      end
      checkOutput("stream_sent", sent, count);
      @(posedge clock); #1;
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic waitDone(input int lowPct);
      int guard = 0;
      bit seen = 1'b0;
      while (!seen && guard < 3000) begin
         @(posedge clock); #1;
         out_ready = ($urandom_range(99, 0) >= lowPct);
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            checkOutput("busy_with_done", busy, 0);
         end
         guard++;
      end
      checkOutput("done_seen", seen, 1);
      out_ready = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      checkOutput("done_once", doneCnt, 1);
      checkOutput("all_outputs", outIdx, TOTAL);
   endtask

   initial begin
      $display("[TB] twiddle_scheduler bench starting");
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checkReset("por");
      reset_n = 1'b1;
      pinModel();

      // Abandon a frame after ten samples with an asynchronous reset.
      noStall = 1'b1;
      fillRandom();
      startFrame();
      applyStimulus(0, 10, -1);
      checkOutput("pre_reset_out_valid", out_valid, 1);
      in_valid = 1'b1;
      #2 reset_n = 1'b0;
      #1 checkReset("midrun");
      @(posedge clock); #1 in_valid = 1'b0;
      @(posedge clock); #1 reset_n = 1'b1;

      // Full frame, no back-pressure, directed twiddle at k = 0.
      fillRandom();
      fillHalf();
      romRe[0] = 16'h0000;
      romIm[0] = 16'h8000;
      startFrame();
      applyStimulus(0, TOTAL, -1);
      waitDone(0);
      checkOutput("out_valid_cycles", outValidCnt, TOTAL);
      checkOutput("s0_n0_upper_re", logRe[0], 16'h4000);
      checkOutput("s0_n0_upper_im", logIm[0], 16'h0000);
      checkOutput("s0_n32_lower_re", logRe[32], 16'h0000);
      checkOutput("s0_n32_lower_im", logIm[32], 16'hC000);
      checkOutput("s5_n0_upper_re", logRe[5*N], 16'h4000);
      checkOutput("s5_n0_upper_im", logIm[5*N], 16'h0000);
      checkOutput("s5_n1_lower_re", logRe[5*N + 1], 16'h0000);
      checkOutput("s5_n1_lower_im", logIm[5*N + 1], 16'hC000);

      // Random data under 30% back-pressure, with a stray start mid-frame.
      noStall = 1'b0;
      out_ready = 1'b1;
      fillRandom();
      startFrame();
      applyStimulus(30, TOTAL, 100);
      waitDone(30);

`ifdef TWIDDLE_CONJ_EN
      // Inverse transform: twiddle imaginary part is conjugated, with a clip case at k = 1.
      noStall = 1'b1;
      out_ready = 1'b1;
      fillRandom();
      fillHalf();
      romRe[0] = 16'h0000;
      romIm[0] = 16'h4000;
      romRe[1] = 16'h1234;
      romIm[1] = 16'h8000;
      inverse  = 1'b1;
      startFrame();
      inverse  = 1'b0;
      applyStimulus(0, TOTAL, -1);
      waitDone(0);
      checkOutput("conj_s5_n1_re", logRe[5*N + 1], 16'h0000);
      checkOutput("conj_s5_n1_im", logIm[5*N + 1], 16'hE000);
`endif

      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule

// File: doc/twiddle_scheduler.md
Name: twiddle_scheduler

Overview:
- Sequences one multi-stage radix-2 DIF FFT frame (N = 2**LOG2N points) through the team's complex multiplier (Q1.(WIDTH-1) inputs, products scaled by >>>(WIDTH-1)).
- Counts stage and sample, issues twiddle ROM addresses, and multiplies lower-leg butterfly outputs by W^k; upper-leg samples pass through unmultiplied.
- Sits between the butterfly unit and the inter-stage buffer, with valid/ready on both sides.

Parameters:
WIDTH, 16, bit width of each real/imag component.
LOG2N, 6, log2 of FFT size; stage count = LOG2N, samples per stage N = 64.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a frame when IDLE.
in_valid  in  1  input sample valid.
in_ready  out  1  block accepts input this cycle.
in_real  in  WIDTH  signed input real part.
in_imag  in  WIDTH  signed input imag part.
tw_addr  out  LOG2N-1  twiddle ROM address k.
tw_en  out  1  ROM read enable; synchronous ROM, data valid the next cycle.
tw_real  in  WIDTH  ROM cos term.
tw_imag  in  WIDTH  ROM -sin term.
out_valid  out  1  output sample valid.
out_ready  in  1  downstream ready.
out_real  out  WIDTH  result real part.
out_imag  out  WIDTH  result imag part.
stage  out  LOG2N-bit-safe ceil(log2(LOG2N))  current stage, 0..LOG2N-1.
busy  out  1  high in RUN or DRAIN.
done  out  1  one-cycle pulse when the frame is fully drained.

Behaviour:
- Reset (async, reset_n=0) clears all state: state=IDLE, sample counter=0, stage=0, in_ready=0, out_valid=0, out_real/out_imag=0, tw_addr=0, tw_en=0, busy=0, done=0. Reset mid-frame abandons the frame; no done pulse.
- FSM IDLE -> RUN on start. RUN -> DRAIN when sample N-1 of stage LOG2N-1 is accepted. DRAIN -> IDLE when the pipeline is empty; done pulses for 1 cycle on that transition.
- start is ignored outside IDLE.
- in_ready = (state==RUN) && advance, where advance = !s2_valid || out_ready.
- Accept = in_valid && in_ready. On accept the sample counter n increments; at n=N-1 it wraps to 0 and stage increments.
- Twiddle, per accepted sample: h = N>>(stage+1). Lower leg iff (n & h) != 0; then k = (n mod h) << stage. Upper leg: k = 0 and a bypass flag is set.
- Pipeline: S0 is accept, with tw_addr=k and tw_en=1 the same cycle. S1 registers the sample and bypass flag while the ROM responds. S2 multiplies (or bypasses) and registers the result into out_*. Latency is 2 cycles accept -> out_valid with no stall.
- Stall: when advance=0, S1, S2 and tw_en all hold; tw_en=0 so ROM data holds. No sample is lost or duplicated under any out_ready pattern.
- Arithmetic: re = (ar*br>>>(W-1)) - (ai*bi>>>(W-1)); im = (ar*bi>>>(W-1)) + (ai*br>>>(W-1)). Results wrap to WIDTH bits with no saturation. Bypass outputs the input unchanged.
- Simultaneous out_ready=0 and in_valid=1 with a full S2: the input is not accepted.

Optional Feature:
- Macro TWIDDLE_CONJ_EN.
- Defined: adds input port inverse (1 bit), sampled on start and held for the frame. When 1, tw_imag is negated before multiplication (IFFT twiddles). Negating -2**(WIDTH-1) gives +(2**(WIDTH-1)-1), saturated.
- Undefined: no port; forward transform only.

Test Plan:
- Reset mid-RUN (after 10 samples) -> all outputs 0 immediately. Next start restarts at stage 0, n=0.
- start, stream 384 samples with out_ready=1 -> in_ready never drops, out_valid exactly 384 cycles at 2-cycle latency, done pulses once, busy falls with done.
- Stage 0: n=32, n=33 -> tw_addr 0, 1. Stage 1: n=16, n=17 -> tw_addr 0, 2. Stage 5: n=1 -> tw_addr 0, and every n=0..63 alternates bypass/multiply.
- in=(0x4000,0) (0.5) with tw=(0,0x8000) on a lower leg -> out=(0,0xC000). Same input on an upper leg -> out=(0x4000,0).
- Random out_ready with 30% low -> output sequence equals the reference model, with no drops or duplicates.
- TWIDDLE_CONJ_EN defined, inverse=1, in=(0x4000,0), tw=(0,0x4000) -> out=(0,0xE000).
